// File: rtl/jk_sequencer.sv
// jk_sequencer: drives a bank of WIDTH JK flip-flops via j/k/pr_n/cl_n and
//   reads the bank q outputs back on q_fb.
// Latency: LOAD/CLEAR/PRESET finish 2 cycles after start. COUNT S finishes
//   after 2S cycles, or 1 cycle when S=0. Each LOAD retry adds 2 cycles.
// Backpressure: start is accepted only in IDLE. A start while busy is dropped.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   start            command strobe
//   mode             00 LOAD, 01 CLEAR, 10 PRESET, 11 COUNT
//   target           LOAD value or COUNT step count
//   q_fb             bank q outputs
//   j, k, pr_n, cl_n registered bank controls, active only during DRIVE
//   busy, done       command in progress; one-cycle completion pulse
//   error            sticky LOAD verify failure
// Optional feature: define JKSEQ_VERIFY_EN to enable LOAD read-back verify
// with up to MAX_RETRY re-drives.
module jk_sequencer #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             pr_n,
  output logic             cl_n,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

  localparam logic [1:0] M_LOAD   = 2'b00;
  localparam logic [1:0] M_CLEAR  = 2'b01;
  localparam logic [1:0] M_PRESET = 2'b10;
  localparam logic [1:0] M_COUNT  = 2'b11;

`ifdef JKSEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] cnt_q;
  logic [RW-1:0]    retry_q;
  logic             err_q;

  // Command source for the next DRIVE: live inputs when leaving IDLE,
  // latched copies when re-entering from SETTLE.
  logic [1:0]       sel_mode;
  logic [WIDTH-1:0] sel_tgt;
  logic [WIDTH-1:0] drv_j;
  logic [WIDTH-1:0] drv_k;
  logic             drv_pr_n;
  logic             drv_cl_n;
  logic [WIDTH-1:0] tmask;

  assign sel_mode = (state == IDLE) ? mode   : mode_q;
  assign sel_tgt  = (state == IDLE) ? target : tgt_q;

  // Synchronous up-count toggle mask: bit i toggles when all lower bits are 1.
  always_comb begin
    tmask    = '0;
    tmask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tmask[i] = tmask[i-1] & q_fb[i-1];
    end
  end

  always_comb begin
    drv_j    = '0;
    drv_k    = '0;
    drv_pr_n = 1'b1;
    drv_cl_n = 1'b1;
    case (sel_mode)
      M_LOAD: begin
        // Set bits that must rise, reset bits that must fall, hold the rest.
        drv_j = sel_tgt & ~q_fb;
        drv_k = ~sel_tgt & q_fb;
      end
      M_CLEAR:  drv_cl_n = 1'b0;
      M_PRESET: drv_pr_n = 1'b0;
      default: begin
        drv_j = tmask;
        drv_k = tmask;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= M_LOAD;
      tgt_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      j       <= '0;
      k       <= '0;
      pr_n    <= 1'b1;
      cl_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Bank controls are idle except in the single cycle after entering DRIVE.
      j    <= '0;
      k    <= '0;
      pr_n <= 1'b1;
      cl_n <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            tgt_q   <= target;
            cnt_q   <= target;
            retry_q <= '0;
            err_q   <= 1'b0;
            busy    <= 1'b1;
            if (mode == M_COUNT && target == '0) begin
              // Zero-step count skips the bank entirely.
              state <= SETTLE;
            end else begin
              state <= DRIVE;
              j     <= drv_j;
              k     <= drv_k;
              pr_n  <= drv_pr_n;
              cl_n  <= drv_cl_n;
            end
          end
        end
        DRIVE: state <= SETTLE;
        SETTLE: begin
          if (mode_q == M_COUNT) begin
            if (cnt_q > 1) begin
              cnt_q <= cnt_q - 1'b1;
              state <= DRIVE;
              j     <= drv_j;
              k     <= drv_k;
            end else begin
              cnt_q <= '0;
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (VERIFY && mode_q == M_LOAD && q_fb != tgt_q) begin
            if (32'(retry_q) < MAX_RETRY) begin
              retry_q <= retry_q + 1'b1;
              state   <= DRIVE;
              j       <= drv_j;
              k       <= drv_k;
            end else begin
              err_q <= 1'b1;
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign error = VERIFY & err_q;

endmodule

// File: tb/tb_jk_sequencer.sv
module tb_jk_sequencer;

  typedef struct {
    int         st;
    int         lat;
    logic [3:0] q;
    logic       err;
    int         drv;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [3:0] target;
  logic [3:0] q_fb;
  logic [3:0] j, k;
  logic       pr_n, cl_n, busy, done, error;

  logic [3:0] q_bank;
  logic       bank_ld;
  logic [3:0] ld_val;
  logic [3:0] stuck_mask;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  jk_sequencer #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .target(target),
    .q_fb(q_fb), .j(j), .k(k), .pr_n(pr_n), .cl_n(cl_n),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // JK bank model; stuck_mask forces selected q bits to read back as 0.
  always @(posedge clk) begin
    if (bank_ld)     q_bank <= ld_val;
    else if (!cl_n)  q_bank <= 4'b0000;
    else if (!pr_n)  q_bank <= 4'b1111;
    else             q_bank <= (j & ~q_bank) | (~k & q_bank);
  end
  assign q_fb = q_bank & ~stuck_mask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: counts drive cycles and pops/compares an expectation on each done.
  int drv_cnt = 0;
  int adj_cnt = 0;
  bit prev_drv = 0;
  always @(negedge clk) begin
    bit   cur;
    exp_t e;
    if (!rst_n) begin
      drv_cnt  = 0;
      adj_cnt  = 0;
      prev_drv = 0;
      chk("done_in_reset", {31'd0, done}, 32'd0);
    end else begin
      cur = ((j | k) != 4'b0000) || !pr_n || !cl_n;
      if (cur) drv_cnt++;
      if (cur && prev_drv) adj_cnt++;
      prev_drv = cur;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("latency",  cyc - e.st, e.lat);
          chk("q_final",  {28'd0, q_fb}, {28'd0, e.q});
          chk("error",    {31'd0, error}, {31'd0, e.err});
          chk("drives",   drv_cnt, e.drv);
          chk("adjacent", adj_cnt, 0);
        end
        drv_cnt = 0;
        adj_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [3:0] t, input int lat,
                       input logic [3:0] eq, input logic ee, input int ed);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    mode   = m;
    target = t;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.st = cyc; e.lat = lat; e.q = eq; e.err = ee; e.drv = ed;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout", {31'd0, n < 40}, 32'd1);
  endtask

  task automatic preload(input logic [3:0] v);
    @(negedge clk);
    bank_ld = 1'b1;
    ld_val  = v;
    @(negedge clk);
    bank_ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; target = 4'd0;
    bank_ld = 1'b0; ld_val = 4'd0; stuck_mask = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_j",     {28'd0, j}, 32'd0);
    chk("rst_k",     {28'd0, k}, 32'd0);
    chk("rst_pr_n",  {31'd0, pr_n}, 32'd1);
    chk("rst_cl_n",  {31'd0, cl_n}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    preload(4'b0110);
    rst_n = 1'b1;

    // LOAD 1010 from 0110
    issue(2'b00, 4'b1010, 2, 4'b1010, 1'b0, 1);
    chk("load_j",    {28'd0, j}, 32'b1000);
    chk("load_k",    {28'd0, k}, 32'b0100);
    chk("load_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("load_j_off", {28'd0, j | k}, 32'd0);
    wait_idle();

    // COUNT 3 from 1110 -> 1111, 0000, 0001
    preload(4'b1110);
    issue(2'b11, 4'd3, 6, 4'b0001, 1'b0, 3);
    chk("count_j1", {28'd0, j}, 32'b0001);
    wait_idle();

    // CLEAR with ignored starts while busy, then PRESET
    issue(2'b01, 4'd0, 2, 4'b0000, 1'b0, 1);
    chk("clear_cl_n", {31'd0, cl_n}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); start = 1'b1; mode = 2'b11; target = 4'd5;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_idle();
    issue(2'b10, 4'd0, 2, 4'b1111, 1'b0, 1);
    chk("preset_pr_n", {31'd0, pr_n}, 32'd0);
    wait_idle();

    // COUNT 0: no drive, done after one cycle
    issue(2'b11, 4'd0, 1, 4'b1111, 1'b0, 0);
    wait_idle();

    // Stuck bit0 bank, LOAD 0001
    stuck_mask = 4'b0001;
    preload(4'b0000);
`ifdef JKSEQ_VERIFY_EN
    issue(2'b00, 4'b0001, 6, 4'b0000, 1'b1, 3);
    wait_idle();
    chk("err_sticky", {31'd0, error}, 32'd1);
`else
    issue(2'b00, 4'b0001, 2, 4'b0000, 1'b0, 1);
    wait_idle();
    chk("err_tied", {31'd0, error}, 32'd0);
`endif
    stuck_mask = 4'b0000;
    issue(2'b01, 4'd0, 2, 4'b0000, 1'b0, 1);
    chk("err_cleared", {31'd0, error}, 32'd0);
    wait_idle();

    // Reset during COUNT 5 at step 2
    preload(4'b0000);
    issue(2'b11, 4'd5, 10, 4'b0101, 1'b0, 5);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_count_j", {28'd0, j}, 32'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mrst_j",    {28'd0, j}, 32'd0);
    chk("mrst_k",    {28'd0, k}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_ctl",  {30'd0, pr_n, cl_n}, 32'b11);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Bank held 0001 from step 1; two more steps give 0011
    issue(2'b11, 4'd2, 4, 4'b0011, 1'b0, 2);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
